// File: rtl/slave_mem_pkg.sv
// Shared definitions for slave_memory_burst: FSM encoding, read latency and the wrapping address step.
// READ_LATENCY is 2 when SLAVE_MEM_OUT_REG_EN is defined, otherwise 1.
package slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

`ifdef SLAVE_MEM_OUT_REG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

    // Memory need not be a power of two, so the wrap is an explicit compare rather than a mask.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] mem_size);
        logic [31:0] next_addr;
        if (addr == (mem_size - 32'd1)) begin
            next_addr = 32'd0;
        end else begin
            next_addr = addr + 32'd1;
        end
        return next_addr;
    endfunction

endpackage

// File: rtl/slave_mem_ram.sv
// Inferred single-port RAM with synchronous read; storage carries no reset.
// With SLAVE_MEM_OUT_REG_EN defined, read data passes through one extra output register.
module slave_mem_ram
    import slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 4096
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_WIDTH = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem_r [0:MEM_SIZE-1];
    logic [DATA_WIDTH-1:0] q_r;
    logic [IDX_WIDTH-1:0]  idx_s;

    assign idx_s = IDX_WIDTH'(addr);

    // Storage port: one write or one synchronous read per enabled cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[idx_s] <= wdata;
            end else begin
                q_r <= mem_r[idx_s];
            end
        end
    end

`ifdef SLAVE_MEM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_r;

    // Extra output stage for timing closure on the read path
    always_ff @(posedge clk) begin
        out_r <= q_r;
    end

    assign rdata = out_r;
`else
    assign rdata = q_r;
`endif

endmodule

// File: rtl/slave_memory_burst.sv
// Burst memory slave: one request of up to 2^LEN_WIDTH beats, wrapping addresses, aligned rvalid/rlast.
// Build option SLAVE_MEM_OUT_REG_EN adds a RAM output register (read latency 2 instead of 1).
module slave_memory_burst
    import slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 4096,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rlast,
    output logic                  wdone,
    output logic                  err
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    state_e                  state_r;
    state_e                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [LEN_WIDTH-1:0]    cnt_r;
    logic [1:0]              drain_cnt_r;
    logic                    err_r;
    logic                    wdone_r;
    logic [READ_LATENCY-1:0] vpipe_r;
    logic [READ_LATENCY-1:0] lpipe_r;
    logic                    req_bad_s;
    logic                    load_s;
    logic                    adv_s;
    logic                    issue_s;
    logic                    last_s;
    logic                    err_next_s;
    logic                    wdone_next_s;
    logic                    ram_en_s;
    logic                    ram_we_s;

    assign req_bad_s   = (32'(req_addr) >= MEM_LIMIT);
    assign addr_next_s = ADDR_WIDTH'(wrap_inc(32'(addr_r), MEM_LIMIT));
    assign last_s      = issue_s && (cnt_r == {LEN_WIDTH{1'b0}});

    // Next-state and per-cycle control decode
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        adv_s        = 1'b0;
        issue_s      = 1'b0;
        err_next_s   = 1'b0;
        wdone_next_s = 1'b0;
        ram_en_s     = 1'b0;
        ram_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad_s) begin
                        err_next_s = 1'b1;
                    end else begin
                        load_s       = 1'b1;
                        state_next_s = req_write ? WRITE : READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (wdata_valid) begin
                    ram_en_s = 1'b1;
                    ram_we_s = 1'b1;
                    adv_s    = 1'b1;
                    if (cnt_r == {LEN_WIDTH{1'b0}}) begin
                        state_next_s = IDLE;
                        wdone_next_s = 1'b1;
                    end else begin
                        state_next_s = WRITE;
                    end
                end else begin
                    state_next_s = WRITE;
                end
            end
            READ: begin
                ram_en_s = 1'b1;
                issue_s  = 1'b1;
                adv_s    = 1'b1;
                if (cnt_r == {LEN_WIDTH{1'b0}}) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = READ;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == 2'd0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, burst bookkeeping and the valid/last pipeline that tracks RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            cnt_r       <= {LEN_WIDTH{1'b0}};
            drain_cnt_r <= 2'd0;
            err_r       <= 1'b0;
            wdone_r     <= 1'b0;
            vpipe_r     <= {READ_LATENCY{1'b0}};
            lpipe_r     <= {READ_LATENCY{1'b0}};
        end else begin
            state_r <= state_next_s;
            err_r   <= err_next_s;
            wdone_r <= wdone_next_s;
            if (load_s) begin
                addr_r <= req_addr;
                cnt_r  <= req_len;
            end else if (adv_s) begin
                addr_r <= addr_next_s;
                cnt_r  <= cnt_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end
            // DRAIN lasts exactly READ_LATENCY cycles
            if ((state_r != DRAIN) && (state_next_s == DRAIN)) begin
                drain_cnt_r <= 2'(READ_LATENCY - 1);
            end else if (state_r == DRAIN) begin
                drain_cnt_r <= drain_cnt_r - 2'd1;
            end
            vpipe_r[0] <= issue_s;
            lpipe_r[0] <= last_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
                lpipe_r[i] <= lpipe_r[i-1];
            end
        end
    end

    slave_mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (addr_r),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign req_ready   = (state_r == IDLE);
    assign wdata_ready = (state_r == WRITE);
    assign rvalid      = vpipe_r[READ_LATENCY-1];
    assign rlast       = lpipe_r[READ_LATENCY-1];
    assign wdone       = wdone_r;
    assign err         = err_r;

endmodule

// File: tb/tb_slave_memory_burst.sv
// Directed bench for slave_memory_burst with a read-data scoreboard and a reference memory model.
// Built with 13-bit addresses so an out-of-range request (0x1000) can be presented.
module tb_slave_memory_burst;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int MS = 4096;
    localparam int LW = 4;
`ifdef SLAVE_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;
    logic          wdone;
    logic          err;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] model_mem [0:MS-1];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    slave_memory_burst #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MS),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rlast       (rlast),
        .wdone       (wdone),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int a);
        return (a == MS - 1) ? 0 : a + 1;
    endfunction

    task automatic do_write(input int addr, input int len, input logic [DW-1:0] base, input bit gaps);
        int a;
        int beat;
        bit on;
        a    = addr;
        beat = 0;
        on   = 1'b1;
        @(negedge clk);
        check("wr_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = AW'(addr);
        req_len   = LW'(len);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (beat <= len) begin
            check("wr_wdata_ready", 32'(wdata_ready), 32'd1);
            check("wr_wdone_quiet", 32'(wdone), 32'd0);
            wdata_valid = on;
            wdata       = base + DW'(beat);
            @(posedge clk);
            if (on) begin
                model_mem[a] = wdata;
                a            = nxt(a);
                beat++;
            end
            if (gaps) on = !on;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        check("wdone_pulse", 32'(wdone), 32'd1);
        check("wr_req_ready_back", 32'(req_ready), 32'd1);
        check("wr_wdata_ready_low", 32'(wdata_ready), 32'd0);
        @(negedge clk);
        check("wdone_once", 32'(wdone), 32'd0);
    endtask

    task automatic do_read(input int addr, input int len);
        int  a;
        int  n;
        bit  exp_v;
        a = addr;
        n = len + 1;
        @(negedge clk);
        check("rd_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = AW'(addr);
        req_len   = LW'(len);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[a]);
            a = nxt(a);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= n + LAT + 1; k++) begin
            exp_v = (k >= 1 + LAT) && (k <= n + LAT);
            check("rd_rvalid", 32'(rvalid), 32'(exp_v));
            check("rd_req_ready_timing", 32'(req_ready), 32'(k >= n + LAT + 1));
            if (rvalid === 1'b1) begin
                check("rd_rlast", 32'(rlast), 32'(k == n + LAT));
                if (exp_q.size() > 0) begin
                    check("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
                end else begin
                    check("rd_sb_underflow", 32'(rvalid), 32'd0);
                end
            end else begin
                check("rd_rlast_idle", 32'(rlast), 32'd0);
            end
            @(negedge clk);
        end
        check("rd_sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_wdata_ready", 32'(wdata_ready), 32'd0);
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rlast", 32'(rlast), 32'd0);
        check("idle_wdone", 32'(wdone), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        // Basic burst round-trip
        do_write(32'h010, 3, 8'hA0, 1'b0);
        do_read(32'h010, 3);

        // Burst wrapping past the top of memory
        do_write(MS - 2, 3, 8'hC0, 1'b0);
        do_read(MS - 2, 3);

        // Write data with gaps: exactly four beats land, fifth word untouched
        do_write(32'h020, 4, 8'h10, 1'b0);
        do_write(32'h020, 3, 8'h50, 1'b1);
        do_read(32'h020, 4);

        // Out-of-range request is rejected
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = AW'(32'h1000);
        req_len   = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_req_ready", 32'(req_ready), 32'd1);
        check("err_wdata_ready", 32'(wdata_ready), 32'd0);
        check("err_no_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_cleared", 32'(err), 32'd0);
            check("err_no_rvalid_after", 32'(rvalid), 32'd0);
            check("err_ready_held", 32'(req_ready), 32'd1);
        end
        do_read(0, 0);

        // Reset in the middle of a 16-beat read
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = AW'(32'h010);
        req_len   = LW'(15);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rvalid_before", 32'(rvalid), 32'd1);
        check("mid_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rvalid_cleared", 32'(rvalid), 32'd0);
        check("mid_rlast_cleared", 32'(rlast), 32'd0);
        check("mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("mid_rvalid_flushed", 32'(rvalid), 32'd0);
        check("mid_req_ready_hold", 32'(req_ready), 32'd1);
        do_read(32'h010, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
